// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity encoding, legal oversample ratios
// and the 3-sample majority vote.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } uart_state_e;

    // Parity type encoding, identical on the TX side.
    localparam logic ParEven = 1'b0;
    localparam logic ParOdd  = 1'b1;

    // Legal oversample ratios.
    localparam int unsigned Prescale8  = 8;
    localparam int unsigned Prescale16 = 16;
    localparam int unsigned Prescale32 = 32;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling counter and 3-sample majority vote around the bit centre.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int unsigned PrescW = 6
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rx_i,
    input  logic              en_i,
    input  logic [PrescW-1:0] prescale_i,
    output logic              bit_val_o,
    output logic              bit_val_vld_o,
    output logic              bit_end_o
);

    logic [PrescW-1:0] edge_cnt_q, edge_cnt_d;
    logic [PrescW-1:0] half, last;
    logic              s0_q, s1_q;
    logic              bit_val_q, bit_val_vld_q;
    logic              at_s0, at_s1, at_s2;

    assign half  = prescale_i >> 1;
    // An illegal prescale of 0 makes last all ones, so the counter still wraps.
    assign last  = prescale_i - PrescW'(1);
    assign at_s0 = (edge_cnt_q == half - PrescW'(1));
    assign at_s1 = (edge_cnt_q == half);
    assign at_s2 = (edge_cnt_q == half + PrescW'(1));

    assign bit_end_o     = en_i && (edge_cnt_q == last);
    assign bit_val_o     = bit_val_q;
    assign bit_val_vld_o = bit_val_vld_q;

    // Edge counter: runs 0..P-1 while a frame is active, parked at 0 otherwise.
    always_comb begin
        edge_cnt_d = '0;
        if (en_i && !bit_end_o) begin
            edge_cnt_d = edge_cnt_q + PrescW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            edge_cnt_q <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
        end
    end

    // Capture the two early samples, then register the vote together with the third.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s0_q          <= 1'b1;
            s1_q          <= 1'b1;
            bit_val_q     <= 1'b1;
            bit_val_vld_q <= 1'b0;
        end else begin
            bit_val_vld_q <= en_i && at_s2;
            if (en_i && at_s0) begin
                s0_q <= rx_i;
            end
            if (en_i && at_s1) begin
                s1_q <= rx_i;
            end
            if (en_i && at_s2) begin
                bit_val_q <= majority3(s0_q, s1_q, rx_i);
            end
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver: frame FSM, data shift register, parity/stop checks and registered result pulses.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int unsigned DataWidth = 8,
    parameter int unsigned PrescW    = 6
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rx_in_i,
    input  logic [PrescW-1:0]    prescale_i,
    input  logic                 par_en_i,
    input  logic                 par_typ_i,
    output logic [DataWidth-1:0] p_data_o,
    output logic                 data_valid_o,
    output logic                 par_err_o,
    output logic                 stp_err_o
);

    localparam int unsigned CntW = (DataWidth > 1) ? $clog2(DataWidth) : 1;

    uart_state_e          state_q, state_d;
    logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DataWidth-1:0] shift_q, shift_d;
    logic [PrescW-1:0]    prescale_q, prescale_d;
    logic                 par_en_q, par_en_d;
    logic                 par_typ_q, par_typ_d;
    logic                 par_bad_q, par_bad_d;
    logic                 stp_bad_q, stp_bad_d;
    logic [DataWidth-1:0] p_data_q, p_data_d;
    logic                 data_valid_q, data_valid_d;
    logic                 par_err_q, par_err_d;
    logic                 stp_err_q, stp_err_d;

    logic bit_val, bit_val_vld, bit_end;
    logic start_det;
    logic frame_ok;

    uart_rx_sampler #(
        .PrescW(PrescW)
    ) u_sampler (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .rx_i         (rx_in_i),
        .en_i         (state_q != StIdle),
        .prescale_i   (prescale_q),
        .bit_val_o    (bit_val),
        .bit_val_vld_o(bit_val_vld),
        .bit_end_o    (bit_end)
    );

    // A start bit abutting the stop bit is taken on the stop exit edge, so back-to-back
    // frames do not slip one cycle per frame.
    assign start_det = ((state_q == StIdle) && !rx_in_i) ||
                       ((state_q == StStop) && bit_end && !rx_in_i);
    assign frame_ok  = !par_bad_q && !stp_bad_q;

    // Next-state, datapath and output-pulse logic.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        prescale_d   = prescale_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        par_bad_d    = par_bad_q;
        stp_bad_d    = stp_bad_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;

        // Frame configuration is frozen for the whole frame.
        if (start_det) begin
            prescale_d = prescale_i;
            par_en_d   = par_en_i;
            par_typ_d  = par_typ_i;
            par_bad_d  = 1'b0;
            stp_bad_d  = 1'b0;
            bit_cnt_d  = '0;
        end

        unique case (state_q)
            StIdle: begin
                if (!rx_in_i) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                // A high vote means the falling edge was a glitch.
                if (bit_end) begin
                    state_d = bit_val ? StIdle : StData;
                end
            end
            StData: begin
                if (bit_val_vld) begin
                    shift_d = {bit_val, shift_q[DataWidth-1:1]};
                end
                if (bit_end) begin
                    if (bit_cnt_q == CntW'(DataWidth - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CntW'(1);
                    end
                end
            end
            StParity: begin
                if (bit_val_vld) begin
                    par_bad_d = (bit_val != (^shift_q ^ par_typ_q));
                end
                if (bit_end) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (bit_val_vld) begin
                    stp_bad_d = !bit_val;
                end
                if (bit_end) begin
                    state_d      = rx_in_i ? StIdle : StStart;
                    data_valid_d = frame_ok;
                    par_err_d    = par_bad_q;
                    stp_err_d    = stp_bad_q;
                    if (frame_ok) begin
                        p_data_d = shift_q;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            prescale_q   <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_bad_q    <= 1'b0;
            stp_bad_q    <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            prescale_q   <= prescale_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            par_bad_q    <= par_bad_d;
            stp_bad_q    <= stp_bad_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign p_data_o     = p_data_q;
    assign data_valid_o = data_valid_q;
    assign par_err_o    = par_err_q;
    assign stp_err_o    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: frames are driven bit by bit on falling clock edges and
// result pulses are logged one time unit after each rising edge.
module tb_uart_rx_frame;
    import uart_pkg::*;

    logic       clk_i;
    logic       rst_ni;
    logic       rx_in_i;
    logic [5:0] prescale_i;
    logic       par_en_i;
    logic       par_typ_i;
    logic [7:0] p_data_o;
    logic       data_valid_o;
    logic       par_err_o;
    logic       stp_err_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Pulse log written only by the monitor process.
    int         cyc = 0;
    int         dv_cnt = 0, pe_cnt = 0, se_cnt = 0;
    int         dv_cyc = 0, dv_cyc_prev = 0, pe_cyc = 0, se_cyc = 0;
    logic [7:0] dv_data = '0, dv_data_prev = '0;
    int         start_cyc = 0;

    uart_rx_frame #(
        .DataWidth(8),
        .PrescW   (6)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .rx_in_i     (rx_in_i),
        .prescale_i  (prescale_i),
        .par_en_i    (par_en_i),
        .par_typ_i   (par_typ_i),
        .p_data_o    (p_data_o),
        .data_valid_o(data_valid_o),
        .par_err_o   (par_err_o),
        .stp_err_o   (stp_err_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Monitor: count pulse cycles and remember when and what they carried.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            cyc++;
            if (data_valid_o === 1'b1) begin
                dv_cnt++;
                dv_cyc_prev  = dv_cyc;
                dv_cyc       = cyc;
                dv_data_prev = dv_data;
                dv_data      = p_data_o;
            end
            if (par_err_o === 1'b1) begin
                pe_cnt++;
                pe_cyc = cyc;
            end
            if (stp_err_o === 1'b1) begin
                se_cnt++;
                se_cyc = cyc;
            end
        end
    end

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk_i);
            rx_in_i = 1'b1;
        end
    endtask

    // Drive one frame; spike_bit/spike_cyc invert the line for one cycle inside that frame bit.
    task automatic send_frame(input logic [7:0] data, input int p, input logic with_par,
                              input logic par_bit, input logic stop_bit,
                              input int spike_bit, input int spike_cyc);
        logic [10:0] bits;
        int          nbits;
        bits  = '0;
        nbits = 0;
        bits[nbits] = 1'b0;
        nbits++;
        for (int i = 0; i < 8; i++) begin
            bits[nbits] = data[i];
            nbits++;
        end
        if (with_par) begin
            bits[nbits] = par_bit;
            nbits++;
        end
        bits[nbits] = stop_bit;
        nbits++;
        for (int i = 0; i < nbits; i++) begin
            for (int j = 0; j < p; j++) begin
                @(negedge clk_i);
                if (i == 0 && j == 0) start_cyc = cyc;
                rx_in_i = bits[i] ^ ((i == spike_bit) && (j == spike_cyc));
            end
        end
    endtask

    task automatic test_reset();
        rst_ni     = 1'b0;
        rx_in_i    = 1'b1;
        prescale_i = 6'd8;
        par_en_i   = 1'b0;
        par_typ_i  = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        n_checks++;
        if (p_data_o !== 8'h00) $display("FAIL reset_p_data: got %h want 00", p_data_o);
        else n_pass++;
        n_checks++;
        if ({data_valid_o, par_err_o, stp_err_o} !== 3'b000)
            $display("FAIL reset_pulses: got %b want 000", {data_valid_o, par_err_o, stp_err_o});
        else n_pass++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        idle(4);
    endtask

    task automatic test_p8_nopar();
        int dv0, pe0, se0;
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        prescale_i = 6'd8;
        par_en_i   = 1'b0;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, -1, -1);
        idle(4);
        n_checks++;
        if (dv_cnt - dv0 !== 1) $display("FAIL p8_dv_count: got %0d want 1", dv_cnt - dv0);
        else n_pass++;
        n_checks++;
        if (dv_data !== 8'hA5) $display("FAIL p8_data: got %h want a5", dv_data);
        else n_pass++;
        n_checks++;
        if (dv_cyc - start_cyc !== 81)
            $display("FAIL p8_latency: got %0d want 81", dv_cyc - start_cyc);
        else n_pass++;
        n_checks++;
        if ((pe_cnt - pe0) + (se_cnt - se0) !== 0)
            $display("FAIL p8_no_err: got %0d want 0", (pe_cnt - pe0) + (se_cnt - se0));
        else n_pass++;
    endtask

    task automatic test_parity();
        int dv0, pe0, se0;
        prescale_i = 6'd16;
        par_en_i   = 1'b1;
        par_typ_i  = ParEven;
        dv0 = dv_cnt; pe0 = pe_cnt;
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, -1, -1);
        idle(4);
        n_checks++;
        if (dv_cnt - dv0 !== 1 || p_data_o !== 8'h3C)
            $display("FAIL even_ok: got dv %0d data %h want 1 3c", dv_cnt - dv0, p_data_o);
        else n_pass++;
        n_checks++;
        if (pe_cnt - pe0 !== 0) $display("FAIL even_ok_pe: got %0d want 0", pe_cnt - pe0);
        else n_pass++;
        // 0xC3 has even weight, so a parity bit of 1 is wrong.
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        send_frame(8'hC3, 16, 1'b1, 1'b1, 1'b1, -1, -1);
        idle(4);
        n_checks++;
        if (pe_cnt - pe0 !== 1) $display("FAIL even_bad_pe: got %0d want 1", pe_cnt - pe0);
        else n_pass++;
        n_checks++;
        if (dv_cnt - dv0 !== 0 || se_cnt - se0 !== 0)
            $display("FAIL even_bad_other: got dv %0d se %0d want 0 0", dv_cnt - dv0, se_cnt - se0);
        else n_pass++;
        n_checks++;
        if (p_data_o !== 8'h3C) $display("FAIL even_bad_hold: got %h want 3c", p_data_o);
        else n_pass++;
    endtask

    task automatic test_stop_err();
        int dv0, pe0, se0;
        prescale_i = 6'd32;
        par_en_i   = 1'b1;
        par_typ_i  = ParOdd;
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        send_frame(8'h00, 32, 1'b1, 1'b1, 1'b0, -1, -1);
        idle(6);
        n_checks++;
        if (se_cnt - se0 !== 1) $display("FAIL stop_se: got %0d want 1", se_cnt - se0);
        else n_pass++;
        n_checks++;
        if (dv_cnt - dv0 !== 0 || pe_cnt - pe0 !== 0)
            $display("FAIL stop_other: got dv %0d pe %0d want 0 0", dv_cnt - dv0, pe_cnt - pe0);
        else n_pass++;
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        send_frame(8'h00, 32, 1'b1, 1'b0, 1'b0, -1, -1);
        idle(6);
        n_checks++;
        if (pe_cnt - pe0 !== 1 || se_cnt - se0 !== 1)
            $display("FAIL both_err: got pe %0d se %0d want 1 1", pe_cnt - pe0, se_cnt - se0);
        else n_pass++;
        n_checks++;
        if (pe_cyc !== se_cyc) $display("FAIL both_same_cycle: got pe@%0d se@%0d", pe_cyc, se_cyc);
        else n_pass++;
        n_checks++;
        if (dv_cnt - dv0 !== 0 || p_data_o !== 8'h3C)
            $display("FAIL both_hold: got dv %0d data %h want 0 3c", dv_cnt - dv0, p_data_o);
        else n_pass++;
    endtask

    task automatic test_glitch();
        int dv0, pe0, se0;
        prescale_i = 6'd16;
        par_en_i   = 1'b0;
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            rx_in_i = 1'b0;
        end
        idle(40);
        n_checks++;
        if ((dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0) !== 0)
            $display("FAIL glitch_pulses: got %0d want 0",
                     (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0));
        else n_pass++;
        n_checks++;
        if (dut.state_q !== StIdle) $display("FAIL glitch_idle: got %0d want 0", dut.state_q);
        else n_pass++;
        dv0 = dv_cnt;
        send_frame(8'h55, 16, 1'b0, 1'b0, 1'b1, -1, -1);
        idle(4);
        n_checks++;
        if (dv_cnt - dv0 !== 1 || dv_data !== 8'h55)
            $display("FAIL glitch_next: got dv %0d data %h want 1 55", dv_cnt - dv0, dv_data);
        else n_pass++;
    endtask

    task automatic test_spike();
        int dv0;
        prescale_i = 6'd16;
        par_en_i   = 1'b0;
        dv0 = dv_cnt;
        // Frame bit 4 is data bit 3; line cycle 9 is the centre sample of that bit.
        send_frame(8'h96, 16, 1'b0, 1'b0, 1'b1, 4, 9);
        idle(4);
        n_checks++;
        if (dv_cnt - dv0 !== 1 || dv_data !== 8'h96)
            $display("FAIL spike: got dv %0d data %h want 1 96", dv_cnt - dv0, dv_data);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int dv0;
        logic [7:0] partial;
        partial = 8'hAA;
        prescale_i = 6'd16;
        par_en_i   = 1'b0;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk_i);
            rx_in_i = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 16; j++) begin
                @(negedge clk_i);
                rx_in_i = partial[i];
            end
        end
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if (p_data_o !== 8'h00 || data_valid_o !== 1'b0)
            $display("FAIL rst_mid_out: got data %h dv %b want 00 0", p_data_o, data_valid_o);
        else n_pass++;
        rx_in_i = 1'b1;
        idle(2);
        rst_ni = 1'b1;
        idle(3);
        dv0 = dv_cnt;
        send_frame(8'hF0, 16, 1'b0, 1'b0, 1'b1, -1, -1);
        idle(4);
        n_checks++;
        if (dv_cnt - dv0 !== 1 || dv_data !== 8'hF0)
            $display("FAIL rst_mid_next: got dv %0d data %h want 1 f0", dv_cnt - dv0, dv_data);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int dv0;
        prescale_i = 6'd16;
        par_en_i   = 1'b0;
        dv0 = dv_cnt;
        send_frame(8'h12, 16, 1'b0, 1'b0, 1'b1, -1, -1);
        send_frame(8'h34, 16, 1'b0, 1'b0, 1'b1, -1, -1);
        idle(4);
        n_checks++;
        if (dv_cnt - dv0 !== 2) $display("FAIL b2b_count: got %0d want 2", dv_cnt - dv0);
        else n_pass++;
        n_checks++;
        if (dv_data_prev !== 8'h12 || dv_data !== 8'h34)
            $display("FAIL b2b_data: got %h %h want 12 34", dv_data_prev, dv_data);
        else n_pass++;
        n_checks++;
        if (dv_cyc - dv_cyc_prev !== 160)
            $display("FAIL b2b_gap: got %0d want 160", dv_cyc - dv_cyc_prev);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_p8_nopar();
        test_parity();
        test_stop_err();
        test_glitch();
        test_spike();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
